reciprocal_fx: RTL and testbench



---
 rtl/reciprocal_fx.sv | 81 ++++++++
 tb/tb_reciprocal_fx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reciprocal_fx.sv
// Registered signed fixed-point reciprocal: o = 1/x (or |1/x|) in QM.N.
// One combinational restoring divider feeds the output registers.
module reciprocal_fx #(
  parameter int M = 16,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M+N-1:0] i_data,
  input  logic           i_abs,
  output logic [M+N-1:0] o_data,
  output logic           o_sat
);

  localparam int W  = M + N;
  localparam int QW = 2 * N + 1;
  localparam int RW = W + 2;
  localparam int CW = ((QW > W) ? QW : W) + 1;

  localparam logic [QW-1:0] DIVIDEND = {1'b1, {(2*N){1'b0}}};
  localparam logic [W:0]    ONE_M    = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0]  MAXW     = {1'b0, {(W-1){1'b1}}};
  localparam logic [CW-1:0] MAXC     = {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};

  logic          neg;
  logic [W:0]    mag;
  logic [RW-1:0] rem;
  logic [QW-1:0] q;
  logic [CW-1:0] q_ext;
  logic [W-1:0]  qw;
  logic          sat_d;
  logic [W-1:0]  data_d;
  logic [W-1:0]  data_q;
  logic          sat_q;

  always_comb begin
    neg    = i_data[W-1] & ~i_abs;
    mag    = {1'b0, i_data};
    rem    = '0;
    q      = '0;
    q_ext  = '0;
    qw     = '0;
    sat_d  = 1'b0;
    data_d = '0;

    if (i_data[W-1])
      mag = ~{1'b1, i_data} + ONE_M;

    // Restoring division of 2^(2N) by mag, MSB first
    for (int i = QW - 1; i >= 0; i--) begin
      rem = {rem[RW-2:0], DIVIDEND[i]};
      if (rem >= {1'b0, mag}) begin
        rem  = rem - {1'b0, mag};
        q[i] = 1'b1;
      end
    end

    q_ext = {{(CW-QW){1'b0}}, q};
    qw    = q_ext[W-1:0];
    sat_d = (mag == '0) || (q_ext > MAXC);

    if (sat_d)
      data_d = neg ? -MAXW : MAXW;
    else
      data_d = neg ? -qw : qw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign o_data = data_q;
  assign o_sat  = sat_q;

endmodule

// File: tb/tb_reciprocal_fx.sv
// Scoreboard bench for reciprocal_fx: directed table plus random sweep
// against a plain-arithmetic floor(2^32/|x|) model.
module tb_reciprocal_fx;

  logic        clk;
  logic        reset;
  logic [31:0] i_data;
  logic        i_abs;
  logic [31:0] o_data;
  logic        o_sat;

  int total;
  int bad;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    string       name;
  } exp_t;

  exp_t sb[$];

  reciprocal_fx #(.M(16), .N(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_data (i_data),
    .i_abs  (i_abs),
    .o_data (o_data),
    .o_sat  (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [31:0] x, bit a);
    exp_t e;
    longint unsigned m;
    longint unsigned q;
    longint unsigned maxv;
    bit n;
    maxv = 64'd2147483647;
    n = x[31] && !a;
    m = x[31] ? (64'd4294967296 - longint'(x)) : longint'(x);
    e.name = "rand";
    if (m == 0) begin
      e.sat  = 1'b1;
      e.data = n ? 32'h80000001 : 32'h7FFFFFFF;
    end else begin
      q = 64'd4294967296 / m;
      if (q > maxv) begin
        e.sat  = 1'b1;
        e.data = n ? 32'h80000001 : 32'h7FFFFFFF;
      end else begin
        e.sat  = 1'b0;
        e.data = n ? 32'(-q) : q[31:0];
      end
    end
    return e;
  endfunction

  task automatic check(string nm, logic [31:0] ad, logic as,
                       logic [31:0] ed, logic es);
    total++;
    if (ad !== ed || as !== es) begin
      bad++;
      $display("FAIL %s: got data=%h sat=%b want data=%h sat=%b",
               nm, ad, as, ed, es);
    end
  endtask

  task automatic issue(logic [31:0] x, bit a, exp_t e);
    @(negedge clk);
    i_data = x;
    i_abs  = a;
    sb.push_back(e);
  endtask

  task automatic issue_d(string nm, logic [31:0] x, bit a,
                         logic [31:0] ed, logic es);
    exp_t e;
    e.data = ed;
    e.sat  = es;
    e.name = nm;
    issue(x, a, e);
  endtask

  // Monitor: each edge presents the result for the operand issued before it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, o_data, o_sat, e.data, e.sat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    bit a;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    i_data = 32'h0;
    i_abs  = 1'b0;
    #1;
    check("reset_init", o_data, o_sat, 32'h0, 1'b0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    reset  = 1'b0;
    i_data = 32'h00010000;
    i_abs  = 1'b0;
    begin
      exp_t e;
      e.data = 32'h00010000; e.sat = 1'b0; e.name = "first_after_reset";
      sb.push_back(e);
    end

    issue_d("one",      32'h00010000, 0, 32'h00010000, 0);
    issue_d("two",      32'h00020000, 0, 32'h00008000, 0);
    issue_d("three",    32'h00030000, 0, 32'h00005555, 0);
    issue_d("lsb3",     32'h00000003, 0, 32'h55555555, 0);
    issue_d("m4_sgn",   32'hFFFC0000, 0, 32'hFFFFC000, 0);
    issue_d("m4_abs",   32'hFFFC0000, 1, 32'h00004000, 0);
    issue_d("m3_trunc", 32'hFFFD0000, 0, 32'hFFFFAAAB, 0);
    issue_d("zero",     32'h00000000, 0, 32'h7FFFFFFF, 1);
    issue_d("zero_abs", 32'h00000000, 1, 32'h7FFFFFFF, 1);
    issue_d("lsb2",     32'h00000002, 0, 32'h7FFFFFFF, 1);
    issue_d("m2lsb",    32'hFFFFFFFE, 0, 32'h80000001, 1);
    issue_d("m2lsb_ab", 32'hFFFFFFFE, 1, 32'h7FFFFFFF, 1);
    issue_d("mostneg",  32'h80000000, 0, 32'hFFFFFFFE, 0);
    issue_d("mostn_ab", 32'h80000000, 1, 32'h00000002, 0);
    issue_d("pos_abs",  32'h00020000, 1, 32'h00008000, 0);
    issue_d("maxpos",   32'h7FFFFFFF, 0, 32'h00000002, 0);
    issue_d("bb_one",   32'h00010000, 0, 32'h00010000, 0);
    issue_d("bb_two",   32'h00020000, 0, 32'h00008000, 0);
    issue_d("bb_zero",  32'h00000000, 0, 32'h7FFFFFFF, 1);
    issue_d("bb_m4",    32'hFFFC0000, 0, 32'hFFFFC000, 0);

    // Asynchronous reset mid-stream, with a nonzero result registered
    @(posedge clk);
    #2;
    check("pre_reset_nonzero", o_data, o_sat, 32'hFFFFC000, 1'b0);
    @(negedge clk);
    i_data = 32'h00010000;
    i_abs  = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_reset", o_data, o_sat, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    begin
      exp_t e;
      e.data = 32'h00010000; e.sat = 1'b0; e.name = "release_reset";
      sb.push_back(e);
    end

    for (int k = 0; k < 600; k++) begin
      a = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: begin
          x = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) x = -x;
        end
        2: begin
          x = 32'h1 << $urandom_range(0, 31);
          if ($urandom_range(0, 1) == 1) x = -x;
        end
        default: x = $urandom >> $urandom_range(0, 31);
      endcase
      issue(x, a, model(x, a));
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want pending=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
